// File: rtl/ledger_pkg.sv
// Shared types and transaction-word field helpers for the ledger validator.
package ledger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ALLOC,
    CHECK,
    WR_SND,
    WR_RCV
  } state_t;

  typedef enum logic [1:0] {
    FUNDS    = 2'd0,
    FULL     = 2'd1,
    OVERFLOW = 2'd2,
    SELF     = 2'd3
  } reason_t;

  localparam int BLOCK_START_BIT = 9;

  // Word layout, MSB first: {sender, receiver, amount, flags}
  function automatic int snd_lsb(input int txn_w, input int id_w);
    return txn_w - id_w;
  endfunction

  function automatic int rcv_lsb(input int txn_w, input int id_w);
    return txn_w - 2 * id_w;
  endfunction

  function automatic int amt_lsb(input int txn_w, input int id_w, input int amt_w);
    return txn_w - 2 * id_w - amt_w;
  endfunction

endpackage

// File: rtl/ledger_ram.sv
// Simple dual-port ledger storage: one write port, one synchronous read port.
module ledger_ram
  import ledger_pkg::*;
#(
  parameter int WIDTH = 72,
  parameter int DEPTH = 16384
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // One-cycle registered read
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ledger_validator.sv
// Transfer validator: looks up sender/receiver in the ledger RAM, allocates
// unknown accounts, checks funds/overflow and writes both entries back.
//
// state  | meaning
// IDLE   | ready for a transaction
// SCAN   | linear search of the visible ledger window
// ALLOC  | self/full checks, allocate missing accounts
// CHECK  | funds and overflow checks, balance update
// WR_SND | write sender entry back
// WR_RCV | write receiver entry back
module ledger_validator
  import ledger_pkg::*;
#(
  parameter int ID_W       = 48,
  parameter int AMT_W      = 22,
  parameter int BAL_W      = 24,
  parameter int DEPTH      = 16384,
  parameter int SCAN_LIMIT = 3000,
  parameter int INIT_BAL   = 100,
  parameter int TXN_W      = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TXN_W-1:0]           data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [TXN_W-1:0]           data_o,
  output logic                       valid_o,
  output logic                       reject_o,
  output logic [1:0]                 reason_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = IDX_W + 1;
  localparam int ENT_W   = ID_W + BAL_W;
  localparam int SND_LSB = snd_lsb(TXN_W, ID_W);
  localparam int RCV_LSB = rcv_lsb(TXN_W, ID_W);
  localparam int AMT_LSB = amt_lsb(TXN_W, ID_W, AMT_W);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  snd_id, rcv_id, rd_id;
  logic [AMT_W-1:0] amount;
  logic [BAL_W-1:0] snd_bal, rcv_bal, rd_bal;
  logic [IDX_W-1:0] snd_idx, rcv_idx, ram_waddr;
  logic             snd_found, rcv_found;
  logic [CNT_W-1:0] count, scan_addr, scan_left, cnt_base, scan_lim;
  logic             ram_we;
  logic [ENT_W-1:0] ram_wdata, ram_rdata;
  logic             snd_hit, rcv_hit, scan_done, is_self, is_full, no_funds, rcv_ovf;
  logic [1:0]       need;
  logic [BAL_W:0]   rcv_sum;

  ledger_ram #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (scan_addr[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  assign ready_o = (state == IDLE);
  assign count_o = count;

  // Scan hit detection, allocation sizing and balance checks
  always_comb begin
    rd_id     = ram_rdata[ENT_W-1:BAL_W];
    rd_bal    = ram_rdata[BAL_W-1:0];
    // read data lags the address by a cycle, so address 0 carries no entry yet
    snd_hit   = (scan_addr != '0) && !snd_found && (rd_id == snd_id);
    rcv_hit   = (scan_addr != '0) && !rcv_found && (rd_id == rcv_id);
    scan_done = (scan_left == '0) ||
                ((snd_found || snd_hit) && (rcv_found || rcv_hit));
    need      = 2'(!snd_found) + 2'(!rcv_found);
    is_self   = (snd_id == rcv_id);
    is_full   = ({1'b0, count} + (CNT_W+1)'(need)) > (CNT_W+1)'(DEPTH);
    no_funds  = {1'b0, snd_bal} < (BAL_W+1)'(amount);
    rcv_sum   = {1'b0, rcv_bal} + (BAL_W+1)'(amount);
    rcv_ovf   = rcv_sum[BAL_W];
    cnt_base  = data_i[BLOCK_START_BIT] ? '0 : count;
    scan_lim  = (32'(cnt_base) > 32'(SCAN_LIMIT)) ? CNT_W'(SCAN_LIMIT) : cnt_base;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = SCAN;
      SCAN:    if (scan_done) state_nxt = ALLOC;
      ALLOC:   state_nxt = (is_self || is_full) ? IDLE : CHECK;
      CHECK:   state_nxt = WR_SND;
      WR_SND:  state_nxt = WR_RCV;
      WR_RCV:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write-back port; reset suppresses a pending write
  always_comb begin
    ram_we    = !rst && ((state == WR_SND) || (state == WR_RCV));
    ram_waddr = (state == WR_SND) ? snd_idx : rcv_idx;
    ram_wdata = (state == WR_SND) ? {snd_id, snd_bal} : {rcv_id, rcv_bal};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Transaction datapath and result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
      reject_o <= 1'b0;
      reason_o <= '0;
    end else begin
      valid_o  <= 1'b0;
      reject_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            data_o    <= data_i;
            snd_id    <= data_i[SND_LSB +: ID_W];
            rcv_id    <= data_i[RCV_LSB +: ID_W];
            amount    <= data_i[AMT_LSB +: AMT_W];
            snd_found <= 1'b0;
            rcv_found <= 1'b0;
            scan_addr <= '0;
            scan_left <= scan_lim;
            if (data_i[BLOCK_START_BIT]) count <= '0;
          end
        end
        SCAN: begin
          scan_addr <= scan_addr + 1'b1;
          scan_left <= scan_left - 1'b1;
          if (snd_hit) begin
            snd_found <= 1'b1;
            snd_idx   <= IDX_W'(scan_addr - 1'b1);
            snd_bal   <= rd_bal;
          end
          if (rcv_hit) begin
            rcv_found <= 1'b1;
            rcv_idx   <= IDX_W'(scan_addr - 1'b1);
            rcv_bal   <= rd_bal;
          end
        end
        ALLOC: begin
          if (is_self) begin
            reject_o <= 1'b1;
            reason_o <= SELF;
          end else if (is_full) begin
            reject_o <= 1'b1;
            reason_o <= FULL;
          end else begin
            if (!snd_found) begin
              snd_idx <= count[IDX_W-1:0];
              snd_bal <= BAL_W'(INIT_BAL);
            end
            if (!rcv_found) begin
              rcv_idx <= IDX_W'(count + CNT_W'(!snd_found));
              rcv_bal <= BAL_W'(INIT_BAL);
            end
            count <= count + CNT_W'(need);
          end
        end
        CHECK: begin
          if (no_funds) begin
            reject_o <= 1'b1;
            reason_o <= FUNDS;
          end else if (rcv_ovf) begin
            reject_o <= 1'b1;
            reason_o <= OVERFLOW;
          end else begin
            snd_bal <= snd_bal - BAL_W'(amount);
            rcv_bal <= rcv_sum[BAL_W-1:0];
            valid_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ledger_validator.sv
// Scoreboard bench for ledger_validator: directed scenarios plus random
// transfers, checked against an array-based ledger model.
module tb_ledger_validator;

  localparam int ID_W       = 48;
  localparam int AMT_W      = 8;
  localparam int BAL_W      = 8;
  localparam int DEPTH      = 8;
  localparam int SCAN_LIMIT = 6;
  localparam int INIT_BAL   = 100;
  localparam int TXN_W      = 128;
  localparam int CNT_W      = $clog2(DEPTH) + 1;
  localparam int NPOOL      = 12;

  typedef struct {
    bit               rej;
    logic [1:0]       reason;
    logic [TXN_W-1:0] data;
    int               when;
    int               cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [TXN_W-1:0] data_i = '0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [TXN_W-1:0] data_o;
  logic             valid_o;
  logic             reject_o;
  logic [1:0]       reason_o;
  logic [CNT_W-1:0] count_o;

  ledger_validator #(
    .ID_W(ID_W), .AMT_W(AMT_W), .BAL_W(BAL_W), .DEPTH(DEPTH),
    .SCAN_LIMIT(SCAN_LIMIT), .INIT_BAL(INIT_BAL), .TXN_W(TXN_W)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .reject_o(reject_o), .reason_o(reason_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  logic [ID_W-1:0] m_id [DEPTH];
  int              m_bal[DEPTH];
  int              m_cnt = 0;
  logic [ID_W-1:0] pool [NPOOL];

  task automatic check(input string name, input logic [TXN_W-1:0] act, input logic [TXN_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference ledger: list of (id, balance) in allocation order
  task automatic model_apply(input logic [ID_W-1:0] s, input logic [ID_W-1:0] r,
                             input int amt, input bit bs, input int e0, output exp_t e);
    int lim, fs, fr, S, need;
    if (bs) m_cnt = 0;
    lim = (m_cnt < SCAN_LIMIT) ? m_cnt : SCAN_LIMIT;
    fs = -1;
    fr = -1;
    for (int i = 0; i < lim; i++) begin
      if (fs < 0 && m_id[i] == s) fs = i;
      if (fr < 0 && m_id[i] == r) fr = i;
    end
    S = (fs >= 0 && fr >= 0) ? (((fs > fr) ? fs : fr) + 1) : lim;
    e.rej    = 1'b1;
    e.reason = 2'd0;
    e.data   = '0;
    e.when   = e0 + S + 2;
    if (s == r) begin
      e.reason = 2'd3;
    end else begin
      need = 0;
      if (fs < 0) need++;
      if (fr < 0) need++;
      if (m_cnt + need > DEPTH) begin
        e.reason = 2'd1;
      end else begin
        e.when = e0 + S + 3;
        if (fs < 0) begin fs = m_cnt; m_id[m_cnt] = s; m_bal[m_cnt] = INIT_BAL; m_cnt++; end
        if (fr < 0) begin fr = m_cnt; m_id[m_cnt] = r; m_bal[m_cnt] = INIT_BAL; m_cnt++; end
        if (m_bal[fs] < amt) e.reason = 2'd0;
        else if (m_bal[fr] + amt > (1 << BAL_W) - 1) e.reason = 2'd2;
        else begin
          m_bal[fs] -= amt;
          m_bal[fr] += amt;
          e.rej = 1'b0;
        end
      end
    end
    e.cnt = m_cnt;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready_o, 1);
  endtask

  task automatic issue(input int si, input int ri, input int amt, input bit bs);
    logic [TXN_W-1:0] w;
    logic [23:0]      flags;
    exp_t             e;
    wait_ready();
    flags    = 24'($urandom);
    flags[9] = bs;
    w = {pool[si], pool[ri], AMT_W'(amt), flags};
    data_i  = w;
    valid_i = 1'b1;
    model_apply(pool[si], pool[ri], amt, bs, cyc + 1, e);
    e.data = w;
    q.push_back(e);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    data_i  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Monitor: pop and compare whenever the DUT presents a result
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid_o || reject_o) begin
        if (q.size() == 0) begin
          check("unexpected_result", {valid_o, reject_o}, 0);
        end else begin
          e = q.pop_front();
          check("result_kind", {valid_o, reject_o}, e.rej ? 2'b01 : 2'b10);
          check("result_cycle", cyc, e.when);
          check("data_o", data_o, e.data);
          check("count_o", count_o, e.cnt);
          if (e.rej) check("reason_o", reason_o, e.reason);
        end
      end else if (q.size() != 0 && cyc > q[0].when) begin
        e = q.pop_front();
        check("result_missing", {valid_o, reject_o}, e.rej ? 2'b01 : 2'b10);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < NPOOL; i++) pool[i] = {16'hAC00 + 16'(i), 32'($urandom)};

    // reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_reject", reject_o, 0);
    check("rst_reason", reason_o, 0);
    check("rst_count", count_o, 0);
    check("rst_data", data_o, 0);
    rst = 1'b0;

    // new accounts, then reverse transfer leaving B empty
    issue(0, 1, 30, 1);
    issue(1, 0, 130, 0);
    issue(1, 0, 1, 0);
    issue(0, 1, 200, 0);

    // insufficient funds on a fresh ledger
    issue(0, 2, 101, 1);
    issue(0, 2, 100, 0);

    // table full, scan window, existing accounts still valid
    issue(0, 1, 1, 1);
    issue(2, 3, 1, 0);
    issue(4, 5, 1, 0);
    issue(6, 7, 1, 0);
    issue(8, 9, 1, 0);
    issue(6, 7, 1, 0);
    issue(0, 1, 1, 0);

    // receiver overflow
    issue(0, 1, 100, 1);
    issue(2, 1, 100, 0);
    issue(1, 2, 55, 0);

    // self transfer
    issue(0, 0, 5, 0);

    // reset in the middle of SCAN
    wait_ready();
    data_i  = {pool[0], pool[1], 8'd1, 24'h0};
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midscan_ready", ready_o, 1);
    check("midscan_count", count_o, 0);
    check("midscan_valid", valid_o, 0);
    check("midscan_reject", reject_o, 0);
    m_cnt = 0;
    issue(0, 1, 30, 0);

    // random traffic
    for (int t = 0; t < 300; t++) begin
      int si, ri, amt;
      si  = $urandom_range(0, NPOOL - 1);
      ri  = ($urandom_range(0, 19) == 0) ? si : $urandom_range(0, NPOOL - 1);
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 60);
      issue(si, ri, amt, $urandom_range(0, 24) == 0);
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
